// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with true-LRU replacement.
// Lookups read pre-update state; updates and lookup touches chain in port order each cycle.
module btb_assoc #(
  parameter int unsigned SETS    = 16,
  parameter int unsigned WAYS    = 4,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned UPD_W   = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [FETCH_W-1:0]       lk_valid,
  input  logic [FETCH_W*PC_W-1:0]  lk_pc,
  output logic [FETCH_W-1:0]       lk_hit,
  output logic [FETCH_W*PC_W-1:0]  lk_target,
  input  logic [UPD_W-1:0]         up_valid,
  input  logic [UPD_W-1:0]         up_inval,
  input  logic [UPD_W*PC_W-1:0]    up_pc,
  input  logic [UPD_W*PC_W-1:0]    up_target
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned AGE_W = $clog2(WAYS);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;
  typedef logic [WAYS-1:0][TAG_W-1:0] tags_t;

  // Make way w MRU; ways younger than it age by one.
  function automatic ages_t touch(input ages_t a, input logic [AGE_W-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) if (a[i] < a[w]) r[i] = a[i] + 1'b1;
    r[w] = '0;
    return r;
  endfunction

  // Make way w LRU; ways older than it move up by one.
  function automatic ages_t demote(input ages_t a, input logic [AGE_W-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) if (a[i] > a[w]) r[i] = a[i] - 1'b1;
    r[w] = '1;
    return r;
  endfunction

  // Returns {hit, way}; tags are unique within a set so at most one way matches.
  function automatic logic [AGE_W:0] find(input logic [WAYS-1:0] v, input tags_t t,
                                          input logic [TAG_W-1:0] tag);
    logic [AGE_W:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++) if (v[i] && t[i] == tag) r = {1'b1, AGE_W'(i)};
    return r;
  endfunction

  function automatic logic [AGE_W-1:0] victim(input logic [WAYS-1:0] v, input ages_t a);
    logic [AGE_W-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++) if (a[i] == '1) r = AGE_W'(i);
    for (int i = WAYS - 1; i >= 0; i--) if (!v[i]) r = AGE_W'(i);
    return r;
  endfunction

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  tags_t           tag_q   [SETS];
  tags_t           tag_d   [SETS];
  ages_t           age_q   [SETS];
  ages_t           age_d   [SETS];
  logic [PC_W-1:0] tgt_q   [SETS][WAYS];
  logic [PC_W-1:0] tgt_d   [SETS][WAYS];
  logic [WAYS-1:0] moved   [SETS];

  logic [FETCH_W-1:0]            hit_q, hit_d;
  logic [FETCH_W*PC_W-1:0]       ltgt_q, ltgt_d;
  logic [FETCH_W-1:0][AGE_W:0]   lk_m;
  logic [FETCH_W-1:0][IDX_W-1:0] lk_set;

  logic [IDX_W-1:0] us;
  logic [TAG_W-1:0] utag;
  logic [AGE_W:0]   um;
  logic [AGE_W-1:0] uw;
  logic             unused_lsbs;

  always_comb begin
    unused_lsbs = 1'b0;
    for (int p = 0; p < FETCH_W; p++) unused_lsbs ^= ^lk_pc[p*PC_W +: 2];
    for (int u = 0; u < UPD_W; u++) unused_lsbs ^= ^up_pc[u*PC_W +: 2];
  end

  always_comb begin
    hit_d  = '0;
    ltgt_d = '0;
    for (int p = 0; p < FETCH_W; p++) begin
      lk_set[p] = lk_pc[p*PC_W+2 +: IDX_W];
      lk_m[p]   = find(valid_q[lk_set[p]], tag_q[lk_set[p]], lk_pc[p*PC_W+IDX_W+2 +: TAG_W]);
      hit_d[p]  = lk_valid[p] & lk_m[p][AGE_W] & ~flush;
      if (hit_d[p]) ltgt_d[p*PC_W +: PC_W] = tgt_q[lk_set[p]][lk_m[p][AGE_W-1:0]];
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    age_d   = age_q;
    tgt_d   = tgt_q;
    us      = '0;
    utag    = '0;
    um      = '0;
    uw      = '0;
    for (int s = 0; s < SETS; s++) moved[s] = '0;

    for (int u = 0; u < UPD_W; u++) begin
      if (up_valid[u]) begin
        us   = up_pc[u*PC_W+2 +: IDX_W];
        utag = up_pc[u*PC_W+IDX_W+2 +: TAG_W];
        um   = find(valid_d[us], tag_d[us], utag);
        if (up_inval[u]) begin
          if (um[AGE_W]) begin
            uw                = um[AGE_W-1:0];
            valid_d[us][uw]   = 1'b0;
            age_d[us]         = demote(age_d[us], uw);
            moved[us][uw]     = 1'b1;
          end
        end else begin
          uw = um[AGE_W] ? um[AGE_W-1:0] : victim(valid_d[us], age_d[us]);
          if (!um[AGE_W]) moved[us][uw] = 1'b1;
          valid_d[us][uw] = 1'b1;
          tag_d[us][uw]   = utag;
          tgt_d[us][uw]   = up_target[u*PC_W +: PC_W];
          age_d[us]       = touch(age_d[us], uw);
        end
      end
    end

    // Lookup touches use pre-update matches; skip ways an update already replaced.
    for (int p = 0; p < FETCH_W; p++) begin
      if (lk_valid[p] && lk_m[p][AGE_W] && !moved[lk_set[p]][lk_m[p][AGE_W-1:0]]) begin
        age_d[lk_set[p]] = touch(age_d[lk_set[p]], lk_m[p][AGE_W-1:0]);
      end
    end

    if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        for (int w = 0; w < WAYS; w++) age_d[s][w] = AGE_W'(w);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        tag_q[s]   <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AGE_W'(w);
          tgt_q[s][w] <= '0;
        end
      end
      hit_q  <= '0;
      ltgt_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      age_q   <= age_d;
      tgt_q   <= tgt_d;
      hit_q   <= hit_d;
      ltgt_q  <= ltgt_d;
    end
  end

  assign lk_hit    = hit_q;
  assign lk_target = ltgt_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed vector bench for btb_assoc (16 sets, 4 ways, 2+2 ports); all vectors hit set 0/1.
module tb_btb_assoc;
  logic          clock;
  logic          reset_n;
  logic          flush;
  logic [1:0]    lk_valid;
  logic [127:0]  lk_pc;
  logic [1:0]    lk_hit;
  logic [127:0]  lk_target;
  logic [1:0]    up_valid;
  logic [1:0]    up_inval;
  logic [127:0]  up_pc;
  logic [127:0]  up_target;

  btb_assoc #(
    .SETS(16), .WAYS(4), .PC_W(64), .FETCH_W(2), .UPD_W(2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .lk_valid  (lk_valid),
    .lk_pc     (lk_pc),
    .lk_hit    (lk_hit),
    .lk_target (lk_target),
    .up_valid  (up_valid),
    .up_inval  (up_inval),
    .up_pc     (up_pc),
    .up_target (up_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  uv;
    logic [1:0]  ui;
    logic [63:0] upc0, utg0, upc1, utg1;
    logic [1:0]  lv;
    logic [63:0] lpc0, lpc1;
    logic        fl;
    logic [1:0]  eh;
    logic [63:0] et0, et1;
  } vec_t;

  vec_t vq[$];
  int   nvec;
  int   nmis;

  function automatic vec_t mk(input logic [1:0] uv, input logic [1:0] ui,
                              input logic [63:0] upc0, input logic [63:0] utg0,
                              input logic [63:0] upc1, input logic [63:0] utg1,
                              input logic [1:0] lv, input logic [63:0] lpc0,
                              input logic [63:0] lpc1, input logic fl, input logic [1:0] eh,
                              input logic [63:0] et0, input logic [63:0] et1);
    vec_t v;
    v.uv = uv; v.ui = ui; v.upc0 = upc0; v.utg0 = utg0; v.upc1 = upc1; v.utg1 = utg1;
    v.lv = lv; v.lpc0 = lpc0; v.lpc1 = lpc1; v.fl = fl;
    v.eh = eh; v.et0 = et0; v.et1 = et1;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    up_valid  = v.uv;
    up_inval  = v.ui;
    up_pc     = {v.upc1, v.upc0};
    up_target = {v.utg1, v.utg0};
    lk_valid  = v.lv;
    lk_pc     = {v.lpc1, v.lpc0};
    flush     = v.fl;
  endtask

  task automatic check_out(input string name, input logic [1:0] eh, input logic [63:0] e0,
                           input logic [63:0] e1);
    nvec++;
    if (lk_hit !== eh || lk_target[63:0] !== e0 || lk_target[127:64] !== e1) begin
      nmis++;
      $display("FAIL %s: got hit=%b t0=%h t1=%h, want hit=%b t0=%h t1=%h", name, lk_hit,
               lk_target[63:0], lk_target[127:64], eh, e0, e1);
    end
  endtask

  initial begin
    vec_t idle;
    nvec = 0;
    nmis = 0;
    idle = mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1'b0, 2'b00, 0, 0);
    reset_n = 1'b0;
    apply(idle);

    //        uv     ui     up0pc    up0tg     up1pc    up1tg     lv     lk0      lk1     fl    eh     et0       et1
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b01, 64'h100, 0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b01, 2'b00, 64'h100, 64'h2000, 0,       0,        2'b01, 64'h100, 0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b01, 64'h100, 0,       0, 2'b01, 64'h2000, 0));
    vq.push_back(mk(2'b01, 2'b00, 64'h100, 64'h3000, 0,       0,        2'b00, 64'h100, 64'h100, 0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b01, 64'h100, 0,       0, 2'b01, 64'h3000, 0));
    vq.push_back(mk(2'b11, 2'b00, 64'h140, 64'h1400, 64'h180, 64'h1800, 2'b00, 0,       0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b01, 2'b00, 64'h1C0, 64'h1C00, 0,       0,        2'b11, 64'h140, 64'h180, 0, 2'b11, 64'h1400, 64'h1800));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h100, 64'h1C0, 0, 2'b11, 64'h3000, 64'h1C00));
    vq.push_back(mk(2'b01, 2'b00, 64'h200, 64'h2200, 0,       0,        2'b01, 64'h140, 0,       0, 2'b01, 64'h1400, 0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h140, 64'h200, 0, 2'b10, 0,        64'h2200));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h100, 64'h180, 0, 2'b11, 64'h3000, 64'h1800));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h1C0, 64'h140, 0, 2'b01, 64'h1C00, 0));
    vq.push_back(mk(2'b11, 2'b00, 64'h100, 64'hA000, 64'h100, 64'hC000, 2'b00, 0,       0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h100, 64'h200, 0, 2'b11, 64'hC000, 64'h2200));
    vq.push_back(mk(2'b11, 2'b00, 64'h240, 64'hA000, 64'h280, 64'hB000, 2'b00, 0,       0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h240, 64'h280, 0, 2'b11, 64'hA000, 64'hB000));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h180, 64'h1C0, 0, 2'b00, 0,        0));
    vq.push_back(mk(2'b11, 2'b11, 64'h200, 0,        64'h700, 0,        2'b01, 64'h200, 0,       0, 2'b01, 64'h2200, 0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h200, 64'h100, 0, 2'b10, 0,        64'hC000));
    vq.push_back(mk(2'b01, 2'b00, 64'h2C0, 64'h2C00, 0,       0,        2'b00, 0,       0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h2C0, 64'h240, 0, 2'b11, 64'h2C00, 64'hA000));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h280, 64'h100, 0, 2'b11, 64'hB000, 64'hC000));
    vq.push_back(mk(2'b01, 2'b00, 64'h104, 64'h5000, 0,       0,        2'b01, 64'h104, 0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h104, 64'h100, 0, 2'b11, 64'h5000, 64'hC000));
    vq.push_back(mk(2'b01, 2'b00, 64'h300, 64'h3300, 0,       0,        2'b11, 64'h100, 64'h104, 1, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h300, 64'h104, 0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b11, 64'h100, 64'h2C0, 0, 2'b00, 0,        0));
    vq.push_back(mk(2'b01, 2'b00, 64'h100, 64'h2000, 0,       0,        2'b00, 0,       0,       0, 2'b00, 0,        0));
    vq.push_back(mk(2'b00, 2'b00, 0,       0,        0,       0,        2'b01, 64'h100, 0,       0, 2'b01, 64'h2000, 0));

    #1;
    check_out("reset_state", 2'b00, 64'h0, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      @(negedge clock);
      check_out($sformatf("vec%0d", i), vq[i].eh, vq[i].et0, vq[i].et1);
    end

    // Async reset between edges while lk_hit is high from the last vector.
    apply(idle);
    #2 reset_n = 1'b0;
    #1 check_out("async_reset_immediate", 2'b00, 64'h0, 64'h0);
    @(negedge clock);
    check_out("async_reset_held", 2'b00, 64'h0, 64'h0);
    reset_n = 1'b1;
    apply(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 64'h100, 64'h2C0, 0, 2'b00, 0, 0));
    @(negedge clock);
    check_out("post_reset_miss", 2'b00, 64'h0, 64'h0);
    apply(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 64'h104, 64'h280, 0, 2'b00, 0, 0));
    @(negedge clock);
    check_out("post_reset_miss2", 2'b00, 64'h0, 64'h0);
    apply(idle);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
